// File: rtl/time_surface_memory_if.sv
// Event input and time-surface read port of the time surface memory.
// The master drives events and read requests; the slave returns decayed cell values.
interface time_surface_memory_if #(
  parameter int unsigned VALUE_BITS = 8
);
  logic                  event_valid;
  logic [8:0]            event_x;
  logic [8:0]            event_y;
  logic                  event_polarity;
  logic [7:0]            ts_read_addr;
  logic                  ts_read_enable;
  logic [VALUE_BITS-1:0] ts_read_value;

  modport master (
    output event_valid,
    output event_x,
    output event_y,
    output event_polarity,
    output ts_read_addr,
    output ts_read_enable,
    input  ts_read_value
  );

  modport slave (
    input  event_valid,
    input  event_x,
    input  event_y,
    input  event_polarity,
    input  ts_read_addr,
    input  ts_read_enable,
    output ts_read_value
  );
endinterface

// File: rtl/time_surface_memory.sv
// 16x16 DVS time surface: per-cell timestamp RAM plus valid bits, a 1-cycle decayed-value
// read port, and a background scrubber that retires stale cells before the tick counter wraps.
module time_surface_memory #(
  parameter int unsigned CLK_FREQ_HZ     = 12_000_000,
  parameter int unsigned DECAY_PERIOD_US = 1000,
  parameter int unsigned VALUE_BITS      = 8,
  parameter int unsigned TS_BITS         = 16,
  parameter int unsigned SENSOR_RES      = 320,
  parameter int unsigned GRID_SHIFT      = 5
) (
  input  logic                        clk,
  input  logic                        rst,
  time_surface_memory_if.slave        bus,
  output logic [TS_BITS-1:0]          debug_now,
  output logic [15:0]                 debug_event_count,
  output logic [15:0]                 debug_drop_count
);

  localparam int unsigned PrescDiv = (CLK_FREQ_HZ / 1_000_000) * DECAY_PERIOD_US;
  localparam int unsigned PrescW   = (PrescDiv > 1) ? $clog2(PrescDiv) : 1;
  localparam logic [PrescW-1:0]     PrescMax = PrescW'(PrescDiv - 1);
  localparam logic [TS_BITS-1:0]    Vmax     = TS_BITS'((1 << VALUE_BITS) - 1);
  localparam logic [VALUE_BITS-1:0] VmaxV    = '1;
  localparam logic [8:0]            Res      = 9'(SENSOR_RES);

  typedef enum logic [0:0] {ScrRd = 1'b0, ScrChk = 1'b1} scr_st_e;

  logic [PrescW-1:0]     r_presc;
  logic [TS_BITS-1:0]    r_now;
  logic [15:0]           r_ev_cnt;
  logic [15:0]           r_drop_cnt;
  logic [255:0]          r_valid;
  logic [TS_BITS-1:0]    r_ts_mem [256];
  logic [TS_BITS-1:0]    r_ram_q;
  scr_st_e               r_scr_st;
  logic [7:0]            r_scr_ptr;
  logic                  r_scr_cancel;
  logic                  r_ext_pend;
  logic [TS_BITS-1:0]    r_rd_now;
  logic                  r_rd_valid;
  logic                  r_rd_byp;
  logic [VALUE_BITS-1:0] r_hold;

  logic                  w_in_range;
  logic [7:0]            w_ev_addr;
  logic                  w_accept;
  logic                  w_drop;
  logic                  w_tick;
  logic                  w_ext_rd;
  logic                  w_scr_rd;
  logic [7:0]            w_ram_raddr;
  logic [TS_BITS-1:0]    w_rd_age;
  logic [TS_BITS-1:0]    w_scr_age;
  logic                  w_scr_expired;
  logic [VALUE_BITS-1:0] w_rd_value;
  logic                  w_unused;

  assign w_in_range  = (bus.event_x < Res) && (bus.event_y < Res);
  assign w_ev_addr   = {bus.event_y[GRID_SHIFT+3:GRID_SHIFT], bus.event_x[GRID_SHIFT+3:GRID_SHIFT]};
  assign w_accept    = bus.event_valid && w_in_range && !rst;
  assign w_drop      = bus.event_valid && !w_in_range;
  assign w_tick      = (r_presc == PrescMax);
  assign w_ext_rd    = bus.ts_read_enable;
  assign w_scr_rd    = (r_scr_st == ScrRd) && !w_ext_rd;
  assign w_ram_raddr = w_ext_rd ? bus.ts_read_addr : r_scr_ptr;
  assign w_rd_age    = r_rd_now - r_ram_q;
  assign w_scr_age   = r_now - r_ram_q;
  // Polarity carries no storage meaning in the time surface.
  assign w_unused    = bus.event_polarity;

  // A clear is suppressed if an event hit the cell while its timestamp was being fetched.
  assign w_scr_expired = r_valid[r_scr_ptr] && (w_scr_age >= Vmax) && !r_scr_cancel;

  always_comb begin
    w_rd_value = '0;
    if (r_rd_byp) begin
      w_rd_value = VmaxV;
    end else if (r_rd_valid && (w_rd_age < Vmax)) begin
      w_rd_value = VALUE_BITS'(Vmax - w_rd_age);
    end
  end

  // Single read / single write port, no reset: maps onto block RAM.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_ts_mem[w_ev_addr] <= r_now;
    end
    if (w_ext_rd || w_scr_rd) begin
      r_ram_q <= r_ts_mem[w_ram_raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_now        <= '0;
      r_ev_cnt     <= '0;
      r_drop_cnt   <= '0;
      r_valid      <= '0;
      r_scr_st     <= ScrRd;
      r_scr_ptr    <= '0;
      r_scr_cancel <= 1'b0;
      r_ext_pend   <= 1'b0;
      r_rd_now     <= '0;
      r_rd_valid   <= 1'b0;
      r_rd_byp     <= 1'b0;
      r_hold       <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_now <= r_now + 1'b1;
      end

      if (w_accept && (r_ev_cnt != 16'hFFFF)) begin
        r_ev_cnt <= r_ev_cnt + 16'd1;
      end
      if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end

      unique case (r_scr_st)
        ScrRd: begin
          if (!w_ext_rd) begin
            r_scr_cancel <= w_accept && (w_ev_addr == r_scr_ptr);
            r_scr_st     <= ScrChk;
          end
        end
        ScrChk: begin
          if (w_scr_expired) begin
            r_valid[r_scr_ptr] <= 1'b0;
          end
          r_scr_ptr <= r_scr_ptr + 8'd1;
          r_scr_st  <= ScrRd;
        end
        default: r_scr_st <= ScrRd;
      endcase

      // Placed after the scrubber clear so a same-cycle event set takes precedence.
      if (w_accept) begin
        r_valid[w_ev_addr] <= 1'b1;
      end

      r_ext_pend <= w_ext_rd;
      if (w_ext_rd) begin
        r_rd_now   <= r_now;
        r_rd_valid <= r_valid[bus.ts_read_addr];
        r_rd_byp   <= w_accept && (w_ev_addr == bus.ts_read_addr);
      end
      if (r_ext_pend) begin
        r_hold <= w_rd_value;
      end
    end
  end

  assign bus.ts_read_value = r_ext_pend ? w_rd_value : r_hold;
  assign debug_now         = r_now;
  assign debug_event_count = r_ev_cnt;
  assign debug_drop_count  = r_drop_cnt;

endmodule

// File: tb/tb_time_surface_memory.sv
// Randomised and directed bench for time_surface_memory against an absolute-time cell model.
// Main instance ticks once per clock; a second idle instance ticks every 3 clocks.
module tb_time_surface_memory;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  time_surface_memory_if #(.VALUE_BITS(8)) tif ();
  time_surface_memory_if #(.VALUE_BITS(8)) tif3 ();

  logic [15:0] dbg_now, dbg_evc, dbg_drop;
  logic [15:0] dbg3_now, dbg3_evc, dbg3_drop;

  time_surface_memory #(
    .CLK_FREQ_HZ(1_000_000), .DECAY_PERIOD_US(1), .VALUE_BITS(8), .TS_BITS(16),
    .SENSOR_RES(320), .GRID_SHIFT(5)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(tif.slave),
    .debug_now(dbg_now), .debug_event_count(dbg_evc), .debug_drop_count(dbg_drop)
  );

  time_surface_memory #(
    .CLK_FREQ_HZ(3_000_000), .DECAY_PERIOD_US(1), .VALUE_BITS(8), .TS_BITS(16),
    .SENSOR_RES(320), .GRID_SHIFT(5)
  ) u_dut3 (
    .clk(clk), .rst(rst), .bus(tif3.slave),
    .debug_now(dbg3_now), .debug_event_count(dbg3_evc), .debug_drop_count(dbg3_drop)
  );

  int     checks = 0;
  int     errors = 0;
  bit     ready = 1'b0;
  longint m_now;
  longint m_last [256];
  int     m_evc, m_drop, exp_val;
  longint c3;

  function automatic int cell_of(input int x, input int y);
    return (y / 32) * 16 + (x / 32);
  endfunction

  function automatic int model_value(input int a);
    longint age;
    if (m_last[a] < 0) return 0;
    age = m_now - m_last[a];
    return (age < 255) ? int'(255 - age) : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: absolute tick time per cell, no wrap, no scrubber detail.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        ready  = 1'b1;
        m_now  = 0;
        c3     = 0;
        m_evc  = 0;
        m_drop = 0;
        exp_val = 0;
        for (int i = 0; i < 256; i++) m_last[i] = -1;
      end else begin
        if (tif.event_valid) begin
          if (int'(tif.event_x) < 320 && int'(tif.event_y) < 320) begin
            m_last[cell_of(int'(tif.event_x), int'(tif.event_y))] = m_now;
            if (m_evc < 65535) m_evc++;
          end else if (m_drop < 65535) begin
            m_drop++;
          end
        end
        if (tif.ts_read_enable) exp_val = model_value(int'(tif.ts_read_addr));
        m_now++;
        c3++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ready) begin
        check("rd_value", 32'(tif.ts_read_value), 32'(exp_val));
        check("now", 32'(dbg_now), 32'(m_now % 65536));
        check("event_count", 32'(dbg_evc), 32'(m_evc));
        check("drop_count", 32'(dbg_drop), 32'(m_drop));
        check("now_div3", 32'(dbg3_now), 32'((c3 / 3) % 65536));
      end
    end
  end

  task automatic idle_inputs();
    tif.event_valid    = 1'b0;
    tif.event_x        = '0;
    tif.event_y        = '0;
    tif.event_polarity = 1'b0;
    tif.ts_read_enable = 1'b0;
    tif.ts_read_addr   = '0;
  endtask

  task automatic step(input bit ev, input int x, input int y, input bit rd, input int a);
    tif.event_valid    = ev;
    tif.event_x        = 9'(x);
    tif.event_y        = 9'(y);
    tif.event_polarity = 1'($urandom % 2);
    tif.ts_read_enable = rd;
    tif.ts_read_addr   = 8'(a);
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    int x, y, a;
    bit ev, rd;
    idle_inputs();
    tif3.event_valid    = 1'b0;
    tif3.event_x        = '0;
    tif3.event_y        = '0;
    tif3.event_polarity = 1'b0;
    tif3.ts_read_enable = 1'b0;
    tif3.ts_read_addr   = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: every cell reads zero after reset
    for (int i = 0; i < 256; i++) begin
      step(1'b0, 0, 0, 1'b1, i);
      check("t1_empty", 32'(tif.ts_read_value), 32'd0);
    end
    check("t1_drop", 32'(dbg_drop), 32'd0);

    // 2: x=100,y=40 -> cell 0x13; one tick per clock here, so next-cycle age is 1
    step(1'b1, 100, 40, 1'b0, 0);
    step(1'b0, 0, 0, 1'b1, 8'h13);
    check("t2_hit", 32'(tif.ts_read_value), 32'd254);
    step(1'b1, 100, 40, 1'b0, 0);
    idle(9);
    step(1'b0, 0, 0, 1'b1, 8'h13);
    check("t2_decay10", 32'(tif.ts_read_value), 32'd245);
    step(1'b0, 0, 0, 1'b1, 8'h12);
    check("t2_neighbour", 32'(tif.ts_read_value), 32'd0);

    // 3: fully decayed at age 255, and no aliasing after the counter wraps
    step(1'b1, 100, 40, 1'b0, 0);
    idle(254);
    step(1'b0, 0, 0, 1'b1, 8'h13);
    check("t3_age255", 32'(tif.ts_read_value), 32'd0);
    idle(65285);
    step(1'b0, 0, 0, 1'b1, 8'h13);
    check("t3_wrap", 32'(tif.ts_read_value), 32'd0);

    // 4: out-of-range events are dropped
    step(1'b1, 320, 10, 1'b0, 0);
    step(1'b1, 10, 511, 1'b0, 0);
    check("t4_drop", 32'(dbg_drop), 32'd2);
    check("t4_evc", 32'(dbg_evc), 32'd3);
    step(1'b0, 0, 0, 1'b1, 8'h0A);
    check("t4_cell_0a", 32'(tif.ts_read_value), 32'd0);
    step(1'b0, 0, 0, 1'b1, 8'hF0);
    check("t4_cell_f0", 32'(tif.ts_read_value), 32'd0);

    // 5a: same-cycle write/read bypass
    step(1'b1, 100, 40, 1'b1, 8'h13);
    check("t5_bypass", 32'(tif.ts_read_value), 32'd255);

    // 5b: stall the scrubber just before 0x13 until the cell is stale, then hit it in the check
    found = 1'b0;
    for (int i = 0; i < 1500 && !found; i++) begin
      if (int'(u_dut.r_scr_st) == 1 && u_dut.r_scr_ptr == 8'h12) found = 1'b1;
      else step(1'b0, 0, 0, 1'b0, 0);
    end
    check("t5_scr_sync", 32'(found), 32'd1);
    for (int i = 0; i < 300; i++) step(1'b0, 0, 0, 1'b1, $urandom % 256);
    step(1'b0, 0, 0, 1'b0, 0);
    check("t5_scr_at_chk", 32'(int'(u_dut.r_scr_st) == 1 && u_dut.r_scr_ptr == 8'h13), 32'd1);
    step(1'b1, 100, 40, 1'b1, 8'h13);
    check("t5_chk_bypass", 32'(tif.ts_read_value), 32'd255);
    step(1'b0, 0, 0, 1'b1, 8'h13);
    check("t5_chk_retained", 32'(tif.ts_read_value), 32'd254);

    // random traffic, weighted toward the reachable 10x10 cells
    for (int i = 0; i < 3000; i++) begin
      ev = ($urandom % 3) == 0;
      x  = $urandom % 400;
      y  = (($urandom % 16) == 0) ? 511 : int'($urandom % 330);
      rd = $urandom % 2;
      a  = int'((($urandom % 10) << 4) | ($urandom % 10));
      if (ev && rd && x < 320 && y < 320 && ($urandom % 8) == 0) a = cell_of(x, y);
      step(ev, x, y, rd, a);
    end

    // 6: continuous reads with a reset in the middle
    for (int i = 0; i < 500; i++) step(1'b0, 0, 0, 1'b1, int'((($urandom % 10) << 4) | ($urandom % 10)));
    rst = 1'b1;
    step(1'b0, 0, 0, 1'b1, 8'h13);
    rst = 1'b0;
    check("t6_rst_value", 32'(tif.ts_read_value), 32'd0);
    check("t6_rst_now", 32'(dbg_now), 32'd0);
    check("t6_rst_evc", 32'(dbg_evc), 32'd0);
    check("t6_rst_drop", 32'(dbg_drop), 32'd0);
    check("t6_rst_now3", 32'(dbg3_now), 32'd0);
    step(1'b0, 0, 0, 1'b1, 8'h13);
    check("t6_post_rst_rd", 32'(tif.ts_read_value), 32'd0);
    idle(2);
    check("t6_now3_tick", 32'(dbg3_now), 32'd1);
    check("t6_now_3", 32'(dbg_now), 32'd3);
    for (int i = 0; i < 500; i++) step(1'b0, 0, 0, 1'b1, $urandom % 256);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
